// File: rtl/dcache_pkg.sv
// -----------------------------------------------------------------------------
// dcache_pkg
// Shared definitions for the direct-mapped write-back data cache:
//   - default geometry and the widths/field positions derived from it
//   - controller state encoding
//   - saturating increment used by the statistics counters
// -----------------------------------------------------------------------------
package dcache_pkg;

   localparam int ADDR_W_DEF    = 32;
   localparam int DATA_W_DEF    = 32;
   localparam int SET_BITS_DEF  = 9;
   localparam int WORD_BITS_DEF = 3;

   // Derived geometry for the default build
   localparam int WORDS   = 2 ** WORD_BITS_DEF;
   localparam int TAG_W   = ADDR_W_DEF - SET_BITS_DEF - WORD_BITS_DEF - 2;

   // Address field positions for the default build
   localparam int OFF_LSB = 2;
   localparam int SET_LSB = WORD_BITS_DEF + 2;
   localparam int TAG_LSB = SET_LSB + SET_BITS_DEF;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WB     = 2'd1,
      FILL   = 2'd2,
      UPDATE = 2'd3
   } state_e;

   // Counter increment that sticks at all-ones instead of wrapping
   function automatic logic [31:0] sat_inc32(input logic [31:0] v);
      if (v == 32'hFFFF_FFFF) begin
         return v;
      end else begin
         return v + 32'd1;
      end
   endfunction

endpackage

// File: rtl/dcache_wb_if.sv
// -----------------------------------------------------------------------------
// dcache_wb_if
// Word-wide request/acknowledge bus between the cache and backing memory.
//   mem_req   cache -> mem  beat request
//   mem_we    cache -> mem  beat is a write-back
//   mem_addr  cache -> mem  word-aligned beat address
//   mem_wdata cache -> mem  write-back data
//   mem_rdata mem -> cache  refill data, sampled on ack
//   mem_ack   mem -> cache  beat completes on a clock edge with mem_req & mem_ack
// master = cache side, slave = memory side.
// -----------------------------------------------------------------------------
interface dcache_wb_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) ();

   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_ack;

   modport master (
      output mem_req, mem_we, mem_addr, mem_wdata,
      input  mem_rdata, mem_ack
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_wdata,
      output mem_rdata, mem_ack
   );

endinterface

// File: rtl/dcache_ctrl.sv
// -----------------------------------------------------------------------------
// dcache_ctrl
// Miss-handling state machine: write-back of a dirty victim, line refill,
// tag update. Owns the beat counter and drives the memory bus from registers.
// Ports:
//   clock_me, reset   clock, asynchronous active-high reset
//   req_s, hit_s      pipeline request present / lookup hit
//   line_valid_s, line_dirty_s, line_tag_s   state of the indexed line
//   req_blk_s         request address above the word offset (tag + set)
//   rd_data_s         data array word selected by rd_word_s (write-back source)
//   rd_word_s         word of the indexed line to present on rd_data_s
//   beat_s            current beat (refill write index)
//   idle_s            controller is idle
//   fill_we_s         refill beat completes this cycle
//   upd_s             line commit cycle
//   mem               memory bus, master side
// -----------------------------------------------------------------------------
module dcache_ctrl
   import dcache_pkg::*;
#(
   parameter int ADDR_W    = ADDR_W_DEF,
   parameter int DATA_W    = DATA_W_DEF,
   parameter int SET_BITS  = SET_BITS_DEF,
   parameter int WORD_BITS = WORD_BITS_DEF
) (
   input  logic                                  clock_me,
   input  logic                                  reset,
   input  logic                                  req_s,
   input  logic                                  hit_s,
   input  logic                                  line_valid_s,
   input  logic                                  line_dirty_s,
   input  logic [ADDR_W-SET_BITS-WORD_BITS-3:0]  line_tag_s,
   input  logic [ADDR_W-WORD_BITS-3:0]           req_blk_s,
   input  logic [DATA_W-1:0]                     rd_data_s,
   output logic [WORD_BITS-1:0]                  rd_word_s,
   output logic [WORD_BITS-1:0]                  beat_s,
   output logic                                  idle_s,
   output logic                                  fill_we_s,
   output logic                                  upd_s,
   dcache_wb_if.master                           mem
);

   localparam logic [WORD_BITS-1:0] LAST_BEAT = {WORD_BITS{1'b1}};

   state_e               state_r;
   logic [WORD_BITS-1:0] beat_r;
   logic [WORD_BITS-1:0] beat_nx_s;
   logic                 mem_req_r;
   logic                 mem_we_r;
   logic [ADDR_W-1:0]    mem_addr_r;
   logic [DATA_W-1:0]    mem_wdata_r;
   logic                 done_s;

   assign beat_nx_s = beat_r + WORD_BITS'(1);
   assign done_s    = mem_req_r & mem.mem_ack;

   assign mem.mem_req   = mem_req_r;
   assign mem.mem_we    = mem_we_r;
   assign mem.mem_addr  = mem_addr_r;
   assign mem.mem_wdata = mem_wdata_r;

   assign beat_s    = beat_r;
   assign idle_s    = (state_r == IDLE);
   assign fill_we_s = (state_r == FILL) & done_s;
   assign upd_s     = (state_r == UPDATE);

   // Write-back source word: the beat that will be presented after the next edge
   always_comb begin
      rd_word_s = {WORD_BITS{1'b0}};
      if (state_r == WB) begin
         rd_word_s = beat_nx_s;
      end else begin
         rd_word_s = {WORD_BITS{1'b0}};
      end
   end

   // Miss FSM with registered bus outputs; next beat is loaded on the ack edge
   always_ff @(posedge clock_me or posedge reset) begin
      if (reset) begin
         state_r     <= IDLE;
         beat_r      <= {WORD_BITS{1'b0}};
         mem_req_r   <= 1'b0;
         mem_we_r    <= 1'b0;
         mem_addr_r  <= {ADDR_W{1'b0}};
         mem_wdata_r <= {DATA_W{1'b0}};
      end else begin
         case (state_r)
            IDLE: begin
               if (req_s && !hit_s) begin
                  mem_req_r <= 1'b1;
                  beat_r    <= {WORD_BITS{1'b0}};
                  if (line_valid_s && line_dirty_s) begin
                     state_r     <= WB;
                     mem_we_r    <= 1'b1;
                     mem_addr_r  <= {line_tag_s, req_blk_s[SET_BITS-1:0],
                                     {WORD_BITS{1'b0}}, 2'b00};
                     mem_wdata_r <= rd_data_s;
                  end else begin
                     state_r    <= FILL;
                     mem_we_r   <= 1'b0;
                     mem_addr_r <= {req_blk_s, {WORD_BITS{1'b0}}, 2'b00};
                  end
               end else begin
                  state_r <= IDLE;
               end
            end
            WB: begin
               if (done_s) begin
                  beat_r <= beat_nx_s;
                  if (beat_r == LAST_BEAT) begin
                     state_r    <= FILL;
                     mem_we_r   <= 1'b0;
                     mem_addr_r <= {req_blk_s, {WORD_BITS{1'b0}}, 2'b00};
                  end else begin
                     mem_addr_r  <= {line_tag_s, req_blk_s[SET_BITS-1:0],
                                     beat_nx_s, 2'b00};
                     mem_wdata_r <= rd_data_s;
                  end
               end else begin
                  state_r <= WB;
               end
            end
            FILL: begin
               if (done_s) begin
                  beat_r <= beat_nx_s;
                  if (beat_r == LAST_BEAT) begin
                     state_r   <= UPDATE;
                     mem_req_r <= 1'b0;
                  end else begin
                     mem_addr_r <= {req_blk_s, beat_nx_s, 2'b00};
                  end
               end else begin
                  state_r <= FILL;
               end
            end
            UPDATE: begin
               state_r <= IDLE;
            end
            default: begin
               state_r   <= IDLE;
               mem_req_r <= 1'b0;
               mem_we_r  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/dcache_wb.sv
// -----------------------------------------------------------------------------
// dcache_wb
// Direct-mapped, write-back, write-allocate data cache for the MEM stage.
// Holds the data/tag/valid/dirty arrays and the hit compare; miss handling
// lives in dcache_ctrl.
// Ports:
//   clock_me, reset     clock, asynchronous active-high reset
//   addr                byte address (bits [1:0] ignored)
//   rmem / wmem         load / store request (store wins when both high)
//   data_in             store data
//   data_out            load data, valid while stall_me is low (combinational)
//   stall_me            pipeline stall (combinational)
//   mem                 backing-memory bus, master side
//   hit_cnt, miss_cnt   saturating statistics, only with DCACHE_STATS_EN
// Optional feature macro: DCACHE_STATS_EN
// -----------------------------------------------------------------------------
module dcache_wb
   import dcache_pkg::*;
#(
   parameter int ADDR_W    = ADDR_W_DEF,
   parameter int DATA_W    = DATA_W_DEF,
   parameter int SET_BITS  = SET_BITS_DEF,
   parameter int WORD_BITS = WORD_BITS_DEF
) (
   input  logic              clock_me,
   input  logic              reset,
   input  logic [ADDR_W-1:0] addr,
   input  logic              rmem,
   input  logic              wmem,
   input  logic [DATA_W-1:0] data_in,
   output logic [DATA_W-1:0] data_out,
   output logic              stall_me,
`ifdef DCACHE_STATS_EN
   output logic [31:0]       hit_cnt,
   output logic [31:0]       miss_cnt,
`endif
   dcache_wb_if.master       mem
);

   localparam int TW         = ADDR_W - SET_BITS - WORD_BITS - 2;
   localparam int SETS       = 2 ** SET_BITS;
   localparam int LINE_WORDS = 2 ** WORD_BITS;

   logic [DATA_W-1:0]    data_arr_r [SETS][LINE_WORDS];
   logic [TW-1:0]        tag_arr_r  [SETS];
   logic [SETS-1:0]      valid_r;
   logic [SETS-1:0]      dirty_r;

   logic [TW-1:0]        tag_s;
   logic [SET_BITS-1:0]  set_s;
   logic [WORD_BITS-1:0] off_s;
   logic                 hit_s;
   logic                 req_s;
   logic                 store_hit_s;
   logic                 idle_s;
   logic                 fill_we_s;
   logic                 upd_s;
   logic [WORD_BITS-1:0] beat_s;
   logic [WORD_BITS-1:0] rd_word_s;
   logic [DATA_W-1:0]    rd_data_s;
   logic                 unused_s;

   assign tag_s    = addr[ADDR_W-1 -: TW];
   assign set_s    = addr[SET_BITS+WORD_BITS+1 : WORD_BITS+2];
   assign off_s    = addr[WORD_BITS+1 : 2];
   assign unused_s = ^addr[1:0];

   assign hit_s       = valid_r[set_s] & (tag_arr_r[set_s] == tag_s);
   assign req_s       = rmem | wmem;
   // A store hit is only taken while idle, so a missing store lands after UPDATE
   assign store_hit_s = idle_s & wmem & hit_s;
   assign stall_me    = ~idle_s | (req_s & ~hit_s);
   assign data_out    = data_arr_r[set_s][off_s];
   assign rd_data_s   = data_arr_r[set_s][rd_word_s];

   dcache_ctrl #(
      .ADDR_W    (ADDR_W),
      .DATA_W    (DATA_W),
      .SET_BITS  (SET_BITS),
      .WORD_BITS (WORD_BITS)
   ) u_ctrl (
      .clock_me     (clock_me),
      .reset        (reset),
      .req_s        (req_s),
      .hit_s        (hit_s),
      .line_valid_s (valid_r[set_s]),
      .line_dirty_s (dirty_r[set_s]),
      .line_tag_s   (tag_arr_r[set_s]),
      .req_blk_s    (addr[ADDR_W-1 : WORD_BITS+2]),
      .rd_data_s    (rd_data_s),
      .rd_word_s    (rd_word_s),
      .beat_s       (beat_s),
      .idle_s       (idle_s),
      .fill_we_s    (fill_we_s),
      .upd_s        (upd_s),
      .mem          (mem)
   );

   // Data array: refill beats and store hits (contents are not reset)
   always_ff @(posedge clock_me) begin
      if (fill_we_s) begin
         data_arr_r[set_s][beat_s] <= mem.mem_rdata;
      end else if (store_hit_s) begin
         data_arr_r[set_s][off_s] <= data_in;
      end
   end

   // Tag array: written when a refilled line is committed
   always_ff @(posedge clock_me) begin
      if (upd_s) begin
         tag_arr_r[set_s] <= tag_s;
      end
   end

   // Valid/dirty bits: reset invalidates every line
   always_ff @(posedge clock_me or posedge reset) begin
      if (reset) begin
         valid_r <= {SETS{1'b0}};
         dirty_r <= {SETS{1'b0}};
      end else if (upd_s) begin
         valid_r[set_s] <= 1'b1;
         dirty_r[set_s] <= 1'b0;
      end else if (store_hit_s) begin
         dirty_r[set_s] <= 1'b1;
      end
   end

`ifdef DCACHE_STATS_EN
   logic [31:0] hit_cnt_r;
   logic [31:0] miss_cnt_r;

   // Statistics: one hit per idle hit cycle, one miss per miss-handling start
   always_ff @(posedge clock_me or posedge reset) begin
      if (reset) begin
         hit_cnt_r  <= 32'd0;
         miss_cnt_r <= 32'd0;
      end else begin
         if (idle_s && req_s && hit_s) begin
            hit_cnt_r <= sat_inc32(hit_cnt_r);
         end
         if (idle_s && req_s && !hit_s) begin
            miss_cnt_r <= sat_inc32(miss_cnt_r);
         end
      end
   end

   assign hit_cnt  = hit_cnt_r;
   assign miss_cnt = miss_cnt_r;
`endif

endmodule
